// File: rtl/tm_pkg.sv
// Shared types and default timing for the Turing machine front end and its program driver.
package tm_pkg;

  localparam int TM_DISP_W     = 11;
  localparam int TM_SETUP_CYC  = 3;
  localparam int TM_PULSE_CYC  = 2;
  localparam int TM_GAP_CYC    = 2;
  localparam int TM_SETTLE_CYC = 5;

  typedef logic [3:0] nibble_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_GAP,
    S_DONE_HI,
    S_DONE_LO,
    S_STEP,
    S_SETTLE,
    S_FINISH
  } drv_state_e;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/tm_prog_mem.sv
// Program nibble store: synchronous write, combinational read, no reset.
module tm_prog_mem
  import tm_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clock,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  nibble_t                  wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output nibble_t                  rd_data
);

  nibble_t mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/tm_program_driver.sv
// Plays a stored program into the Turing machine as input_data/Next/Done strobes, then
// steps the machine with Next pulses and snapshots its display until done or a step limit.
module tm_program_driver
  import tm_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int DISP_W     = TM_DISP_W,
  parameter int SETUP_CYC  = TM_SETUP_CYC,
  parameter int PULSE_CYC  = TM_PULSE_CYC,
  parameter int GAP_CYC    = TM_GAP_CYC,
  parameter int SETTLE_CYC = TM_SETTLE_CYC,
  parameter int MAX_STEPS  = 255
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  nibble_t                  wr_data,
  input  logic [$clog2(DEPTH):0]   prog_len,
  input  logic                     start,
  input  logic [DISP_W-1:0]        display_in,
  input  logic                     compute_done_in,
  output nibble_t                  input_data,
  output logic                     Next,
  output logic                     Done,
  output logic                     busy,
  output logic                     load_done,
  output logic [DISP_W-1:0]        display_snap,
  output logic [7:0]               step_count,
  output logic                     halted,
  output logic                     halt_by_limit,
  output drv_state_e               state_dbg
);

  localparam int AW     = $clog2(DEPTH);
  localparam int LW     = AW + 1;
  localparam int PH_MAX = max4(max4(SETUP_CYC, PULSE_CYC, GAP_CYC, SETTLE_CYC), 1, 1, 1);
  localparam int PW     = $clog2(PH_MAX + 1);

  drv_state_e        state_q, state_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [LW-1:0]     idx_q, idx_d, len_q, len_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DISP_W-1:0] snap_q, snap_d;
  logic              lim_q, lim_d;
  nibble_t           rd_data;

  function automatic logic at_last(input logic [PW-1:0] ph, input int n);
    return ph == PW'(n - 1);
  endfunction

  tm_prog_mem #(.DEPTH(DEPTH)) u_mem (
    .clock   (clock),
    .wr_en   (wr_en && (state_q == S_IDLE)),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx_q[AW-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      snap_q  <= '0;
      lim_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      lim_q   <= lim_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q + 1'b1;
    idx_d   = idx_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    lim_d   = lim_q;
    case (state_q)
      S_IDLE: begin
        phase_d = '0;
        if (start) begin
          len_d   = (prog_len > LW'(DEPTH)) ? LW'(DEPTH) : prog_len;
          idx_d   = '0;
          cnt_d   = '0;
          snap_d  = '0;
          lim_d   = 1'b0;
          state_d = (len_d == '0) ? S_DONE_HI : S_SETUP;
        end
      end
      S_SETUP: if (at_last(phase_q, SETUP_CYC)) begin phase_d = '0; state_d = S_PULSE; end
      S_PULSE: if (at_last(phase_q, PULSE_CYC)) begin phase_d = '0; state_d = S_GAP; end
      S_GAP: begin
        if (at_last(phase_q, GAP_CYC)) begin
          phase_d = '0;
          idx_d   = idx_q + 1'b1;
          state_d = (idx_d == len_q) ? S_DONE_HI : S_SETUP;
        end
      end
      S_DONE_HI: if (at_last(phase_q, PULSE_CYC)) begin phase_d = '0; state_d = S_DONE_LO; end
      S_DONE_LO: if (at_last(phase_q, GAP_CYC)) begin phase_d = '0; state_d = S_STEP; end
      S_STEP:    if (at_last(phase_q, PULSE_CYC)) begin phase_d = '0; state_d = S_SETTLE; end
      S_SETTLE: begin
        if (at_last(phase_q, SETTLE_CYC)) begin
          phase_d = '0;
          snap_d  = display_in;
          // Saturating count; the limit test below keeps it from ever exceeding MAX_STEPS.
          if (cnt_q != 8'(MAX_STEPS)) cnt_d = cnt_q + 8'd1;
          if (compute_done_in) begin
            lim_d   = 1'b0;
            state_d = S_FINISH;
          end else if (({1'b0, cnt_q} + 9'd1) == 9'(MAX_STEPS)) begin
            lim_d   = 1'b1;
            state_d = S_FINISH;
          end else begin
            state_d = S_STEP;
          end
        end
      end
      S_FINISH: begin
        phase_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        phase_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Every output is a registered image of the state above, one cycle behind it.
  always_ff @(posedge clock) begin
    if (reset) begin
      input_data    <= '0;
      Next          <= 1'b0;
      Done          <= 1'b0;
      busy          <= 1'b0;
      load_done     <= 1'b0;
      display_snap  <= '0;
      step_count    <= '0;
      halted        <= 1'b0;
      halt_by_limit <= 1'b0;
    end else begin
      if (state_q == S_SETUP || state_q == S_PULSE || state_q == S_GAP) input_data <= rd_data;
      Next          <= (state_q == S_PULSE) || (state_q == S_STEP);
      Done          <= (state_q == S_DONE_HI);
      busy          <= (state_q != S_IDLE);
      load_done     <= (state_q == S_STEP) || (state_q == S_SETTLE) || (state_q == S_FINISH);
      display_snap  <= snap_q;
      step_count    <= cnt_q;
      halted        <= (state_q == S_FINISH);
      halt_by_limit <= lim_q;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_tm_program_driver.sv
// Scoreboarded bench for tm_program_driver: load timing, run phase, limits, aborts.
module tb_tm_program_driver;
  import tm_pkg::*;

  localparam int DEPTH = 64;
  localparam int DW    = 11;

  logic          clock = 1'b0;
  logic          reset, wr_en, start, start_lim;
  logic [5:0]    wr_addr;
  logic [3:0]    wr_data;
  logic [6:0]    prog_len;
  logic [DW-1:0] display_in;
  logic          compute_done_in;

  logic [3:0]    input_data, l_input_data;
  logic          Next, Done, busy, load_done, halted, halt_by_limit;
  logic          l_next, l_done, l_busy, l_load_done, l_halted, l_halt_by_limit;
  logic [DW-1:0] display_snap, l_display_snap;
  logic [7:0]    step_count, l_step_count;
  drv_state_e    state_dbg, l_state_dbg;

  tm_program_driver dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .prog_len(prog_len), .start(start), .display_in(display_in),
    .compute_done_in(compute_done_in), .input_data(input_data), .Next(Next), .Done(Done),
    .busy(busy), .load_done(load_done), .display_snap(display_snap),
    .step_count(step_count), .halted(halted), .halt_by_limit(halt_by_limit),
    .state_dbg(state_dbg)
  );

  tm_program_driver #(.MAX_STEPS(3)) dut_lim (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .prog_len(prog_len), .start(start_lim), .display_in(display_in),
    .compute_done_in(compute_done_in), .input_data(l_input_data), .Next(l_next),
    .Done(l_done), .busy(l_busy), .load_done(l_load_done), .display_snap(l_display_snap),
    .step_count(l_step_count), .halted(l_halted), .halt_by_limit(l_halt_by_limit),
    .state_dbg(l_state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  // machine model: display advances once per run-phase Next pulse
  logic [DW-1:0] disp_model;
  int            steps_seen, cd_step;
  assign display_in      = disp_model;
  assign compute_done_in = (cd_step != 0) && (steps_seen >= cd_step);

  // monitor view of whichever instance is under test
  logic          sel;
  logic [3:0]    m_input_data;
  logic          m_next, m_done, m_busy, m_load_done, m_halted, m_lim;
  logic [DW-1:0] m_snap;
  logic [7:0]    m_cnt;
  assign m_input_data = sel ? l_input_data    : input_data;
  assign m_next       = sel ? l_next          : Next;
  assign m_done       = sel ? l_done          : Done;
  assign m_busy       = sel ? l_busy          : busy;
  assign m_load_done  = sel ? l_load_done     : load_done;
  assign m_halted     = sel ? l_halted        : halted;
  assign m_lim        = sel ? l_halt_by_limit : halt_by_limit;
  assign m_snap       = sel ? l_display_snap  : display_snap;
  assign m_cnt        = sel ? l_step_count    : step_count;

  // scoreboard
  int            checks = 0;
  int            fails  = 0;
  logic [3:0]    prog [DEPTH];
  int            exp_next_t_q[$];
  logic          exp_next_ld_q[$];
  logic [3:0]    exp_nib_q[$];
  int            exp_snap_t_q[$];
  logic [DW-1:0] exp_snap_q[$];
  logic [7:0]    exp_cnt_q[$];
  int            exp_done_t, exp_ld_t, exp_halt_t;
  logic          exp_lim;

  // driver tasks
  task automatic write_mem(input int addr, input logic [3:0] data);
    @(negedge clock);
    wr_en = 1'b1; wr_addr = 6'(addr); wr_data = data; prog[addr] = data;
    @(posedge clock); #1;
    wr_en = 1'b0;
  endtask

  task automatic do_start(input logic which, input logic wr, input int addr, input logic [3:0] data);
    @(negedge clock);
    if (which) start_lim = 1'b1; else start = 1'b1;
    if (wr) begin
      wr_en = 1'b1; wr_addr = 6'(addr); wr_data = data; prog[addr] = data;
    end
    steps_seen = 0;
    disp_model = DW'($urandom_range(0, 2047));
    @(posedge clock); #1;
    start = 1'b0; start_lim = 1'b0; wr_en = 1'b0;
  endtask

  // Expected event times are relative to the start edge (cycle 0).
  task automatic push_expect(input int n, input int s, input logic lim);
    exp_next_t_q.delete(); exp_next_ld_q.delete(); exp_nib_q.delete();
    exp_snap_t_q.delete(); exp_snap_q.delete(); exp_cnt_q.delete();
    for (int k = 0; k < n; k++) begin
      exp_next_t_q.push_back(7 * k + 4); exp_next_ld_q.push_back(1'b0);
      exp_nib_q.push_back(prog[k]);
    end
    exp_done_t = 7 * n + 1;
    exp_ld_t   = 7 * n + 5;
    for (int j = 1; j <= s; j++) begin
      exp_next_t_q.push_back(7 * n + 5 + 7 * (j - 1)); exp_next_ld_q.push_back(1'b1);
      exp_snap_t_q.push_back(7 * n + 5 + 7 * j);
      exp_snap_q.push_back(disp_model + DW'(j));
      exp_cnt_q.push_back(8'(j));
    end
    exp_halt_t = 7 * n + 5 + 7 * s;
    exp_lim    = lim;
  endtask

  task automatic run_sequence(input int inj_t);
    logic prev_next = 1'b0, prev_done = 1'b0, prev_ld = 1'b0;
    int   halted_seen = 0;
    int   t_e;
    logic ld_e;
    logic [3:0] nib_e;
    for (int t = 0; t <= exp_halt_t + 3; t++) begin
      @(negedge clock);
      if (m_next && !prev_next) begin
        checks++;
        if (exp_next_t_q.size() == 0) begin
          fails++; $display("FAIL next_extra: Next rose at cycle %0d, none expected", t);
        end else begin
          t_e = exp_next_t_q.pop_front(); ld_e = exp_next_ld_q.pop_front();
          if (t !== t_e) begin fails++; $display("FAIL next_time: got %0d expected %0d", t, t_e); end
          checks++;
          if (m_load_done !== ld_e) begin
            fails++; $display("FAIL next_phase: load_done %0b expected %0b at %0d", m_load_done, ld_e, t);
          end
          if (!ld_e) begin
            nib_e = exp_nib_q.pop_front();
            checks++;
            if (m_input_data !== nib_e) begin
              fails++; $display("FAIL nibble: got %0d expected %0d at %0d", m_input_data, nib_e, t);
            end
          end
        end
        if (m_load_done) begin steps_seen++; disp_model = disp_model + 1'b1; end
      end
      if (m_done && !prev_done) begin
        checks++;
        if (t !== exp_done_t) begin fails++; $display("FAIL done_time: got %0d expected %0d", t, exp_done_t); end
      end
      if (m_load_done && !prev_ld) begin
        checks++;
        if (t !== exp_ld_t) begin fails++; $display("FAIL load_done_time: got %0d expected %0d", t, exp_ld_t); end
      end
      if (exp_snap_t_q.size() != 0 && t == exp_snap_t_q[0]) begin
        void'(exp_snap_t_q.pop_front());
        checks++;
        if (m_snap !== exp_snap_q[0]) begin
          fails++; $display("FAIL snap: got %0d expected %0d at %0d", m_snap, exp_snap_q[0], t);
        end
        checks++;
        if (m_cnt !== exp_cnt_q[0]) begin
          fails++; $display("FAIL step_count: got %0d expected %0d at %0d", m_cnt, exp_cnt_q[0], t);
        end
        void'(exp_snap_q.pop_front()); void'(exp_cnt_q.pop_front());
      end
      if (m_halted) begin
        halted_seen++;
        checks++;
        if (t !== exp_halt_t) begin fails++; $display("FAIL halt_time: got %0d expected %0d", t, exp_halt_t); end
        checks++;
        if (m_lim !== exp_lim) begin fails++; $display("FAIL halt_by_limit: got %0b expected %0b", m_lim, exp_lim); end
      end
      if (t == exp_halt_t + 1) begin
        checks++;
        if (m_busy !== 1'b0 || m_load_done !== 1'b0) begin
          fails++; $display("FAIL idle_after: busy %0b load_done %0b expected 0 0", m_busy, m_load_done);
        end
      end
      if (t == inj_t) begin
        wr_en = 1'b1; wr_addr = 6'd0; wr_data = ~prog[0]; start = 1'b1;
      end
      if (t == inj_t + 1) begin
        wr_en = 1'b0; start = 1'b0;
      end
      prev_next = m_next; prev_done = m_done; prev_ld = m_load_done;
    end
    checks++;
    if (halted_seen !== 1) begin fails++; $display("FAIL halted_count: got %0d expected 1", halted_seen); end
    checks++;
    if (exp_next_t_q.size() + exp_snap_t_q.size() != 0) begin
      fails++; $display("FAIL missing_events: %0d expected events never seen", exp_next_t_q.size() + exp_snap_t_q.size());
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({input_data, Next, Done, busy, load_done, halted, halt_by_limit} !== 10'd0 ||
        display_snap !== '0 || step_count !== 8'd0) begin
      fails++;
      $display("FAIL %s: data %0d next %0b done %0b busy %0b ld %0b snap %0d cnt %0d halt %0b lim %0b expected all 0",
               name, input_data, Next, Done, busy, load_done, display_snap, step_count, halted, halt_by_limit);
    end
  endtask

  // scenarios
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_zero("reset_outputs");
    checks++;
    if (state_dbg !== S_IDLE) begin fails++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, S_IDLE); end
    reset = 1'b0;
  endtask

  task automatic test_load_basic;
    write_mem(0, 4'd3); write_mem(1, 4'd1); write_mem(2, 4'd0);
    prog_len = 7'd3; cd_step = 1; sel = 1'b0;
    do_start(1'b0, 1'b0, 0, 4'd0);
    push_expect(3, 1, 1'b0);
    run_sequence(-10);
  endtask

  task automatic test_empty;
    prog_len = 7'd0; cd_step = 1;
    do_start(1'b0, 1'b0, 0, 4'd0);
    push_expect(0, 1, 1'b0);
    run_sequence(-10);
  endtask

  task automatic test_compute_done;
    for (int a = 1; a < 5; a++) write_mem(a, 4'($urandom_range(0, 15)));
    prog_len = 7'd5; cd_step = 4;
    // write to address 0 lands in the same cycle as start
    do_start(1'b0, 1'b1, 0, 4'($urandom_range(0, 15)));
    push_expect(5, 4, 1'b0);
    run_sequence(-10);
  endtask

  task automatic test_back_to_back;
    prog_len = 7'd3; cd_step = 1;
    do_start(1'b0, 1'b0, 0, 4'd0);
    push_expect(3, 1, 1'b0);
    run_sequence(9);
    do_start(1'b0, 1'b0, 0, 4'd0);
    push_expect(3, 1, 1'b0);
    run_sequence(-10);
  endtask

  task automatic test_reset_mid_load;
    write_mem(0, 4'd5); write_mem(1, 4'd9); write_mem(2, 4'd12);
    prog_len = 7'd3; cd_step = 1;
    do_start(1'b0, 1'b0, 0, 4'd0);
    for (int t = 0; t <= 11; t++) begin
      @(negedge clock);
      if (t == 10) begin
        checks++;
        if (input_data !== 4'd9) begin fails++; $display("FAIL pre_reset_data: got %0d expected 9", input_data); end
        reset = 1'b1;
      end
      if (t == 11) begin
        check_zero("mid_reset_outputs");
        reset = 1'b0;
      end
    end
    repeat (3) @(negedge clock);
    do_start(1'b0, 1'b0, 0, 4'd0);
    push_expect(3, 1, 1'b0);
    run_sequence(-10);
  endtask

  task automatic test_limit;
    write_mem(0, 4'd7); write_mem(1, 4'd2);
    prog_len = 7'd2; cd_step = 0; sel = 1'b1;
    do_start(1'b1, 1'b0, 0, 4'd0);
    push_expect(2, 3, 1'b1);
    run_sequence(-10);
    checks++;
    if (l_step_count !== 8'd3) begin fails++; $display("FAIL limit_count: got %0d expected 3", l_step_count); end
    sel = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; prog_len = '0;
    start = 1'b0; start_lim = 1'b0; disp_model = '0; steps_seen = 0; cd_step = 0; sel = 1'b0;
    test_reset;
    test_load_basic;
    test_empty;
    test_compute_done;
    test_back_to_back;
    test_reset_mid_load;
    test_limit;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
